// File: rtl/ysyx_220066_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM encoding,
// mcause values and timer reset values.
package ysyx_220066_trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } trap_state_t;

  localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_ILL     = 64'd2;
  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

  localparam logic [63:0] MTIME_RST    = 64'h0;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/ysyx_220066_mtimer.sv
// Machine timer: prescaled mtime counter, mtimecmp register and a registered
// pending flag computed from the post-update register values.
module ysyx_220066_mtimer
  import ysyx_220066_trap_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tmr_wen,
  input  logic        tmr_sel,
  input  logic [63:0] tmr_wdata,
  output logic [63:0] mtime,
  output logic        mtip
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_reg, presc_next;
  logic [63:0]   mtime_reg, mtime_next;
  logic [63:0]   mtimecmp_reg, mtimecmp_next;
  logic          mtip_reg;

  always_comb begin
    presc_next    = presc_reg;
    mtime_next    = mtime_reg;
    mtimecmp_next = mtimecmp_reg;
    // A software write to mtime replaces this cycle's tick and restarts the prescaler.
    if (tmr_wen && !tmr_sel) begin
      mtime_next = tmr_wdata;
      presc_next = '0;
    end else if (presc_reg == PRESC_LAST) begin
      mtime_next = mtime_reg + 64'd1;
      presc_next = '0;
    end else begin
      presc_next = presc_reg + PW'(1);
    end
    if (tmr_wen && tmr_sel) begin
      mtimecmp_next = tmr_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg    <= '0;
      mtime_reg    <= MTIME_RST;
      mtimecmp_reg <= MTIMECMP_RST;
      mtip_reg     <= 1'b0;
    end else begin
      presc_reg    <= presc_next;
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      mtip_reg     <= (mtime_next >= mtimecmp_next);
    end
  end

  assign mtime = mtime_reg;
  assign mtip  = mtip_reg;

endmodule

// File: rtl/ysyx_220066_trap_ctrl.sv
// Trap sequencer between the commit stage and the CSR file: selects the
// highest-priority event, issues one trap/mret pulse, then drains the pipeline.
module ysyx_220066_trap_ctrl
  import ysyx_220066_trap_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 10,
  parameter int DRAIN_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic        commit_ecall,
  input  logic        commit_ill,
  input  logic        commit_mret,
  input  logic        mstatus_mie,
  input  logic        mie_mtie,
  input  logic        tmr_wen,
  input  logic        tmr_sel,
  input  logic [63:0] tmr_wdata,
  output logic [63:0] mtime,
  output logic        mtip,
  output logic        stall,
  output logic        flush,
  output logic        raise_intr,
  output logic        ret,
  output logic [63:0] NO,
  output logic [63:0] trap_pc
);

  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);

  trap_state_t   state_reg;
  logic [CW-1:0] drain_cnt_reg;
  logic          stall_reg, flush_reg, raise_reg, ret_reg;
  logic [63:0]   cause_reg, trap_pc_reg;

  logic          take_trap, take_ret;
  logic [63:0]   cause_next;

  ysyx_220066_mtimer #(
    .TICK_DIV (TICK_DIV)
  ) u_mtimer (
    .clk       (clk),
    .rst       (rst),
    .tmr_wen   (tmr_wen),
    .tmr_sel   (tmr_sel),
    .tmr_wdata (tmr_wdata),
    .mtime     (mtime),
    .mtip      (mtip)
  );

  // Fixed priority: enabled timer interrupt, illegal instruction, ecall, mret.
  always_comb begin
    take_trap  = 1'b0;
    take_ret   = 1'b0;
    cause_next = cause_reg;
    if (commit_valid) begin
      if (mtip && mstatus_mie && mie_mtie) begin
        take_trap  = 1'b1;
        cause_next = CAUSE_MTI;
      end else if (commit_ill) begin
        take_trap  = 1'b1;
        cause_next = CAUSE_ILL;
      end else if (commit_ecall) begin
        take_trap  = 1'b1;
        cause_next = CAUSE_ECALL_M;
      end else if (commit_mret) begin
        take_ret = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      drain_cnt_reg <= '0;
      stall_reg     <= 1'b0;
      flush_reg     <= 1'b0;
      raise_reg     <= 1'b0;
      ret_reg       <= 1'b0;
      cause_reg     <= 64'h0;
      trap_pc_reg   <= 64'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          stall_reg <= 1'b0;
          flush_reg <= 1'b0;
          raise_reg <= 1'b0;
          ret_reg   <= 1'b0;
          if (take_trap || take_ret) begin
            state_reg <= ST_ISSUE;
            stall_reg <= 1'b1;
            flush_reg <= 1'b1;
            raise_reg <= take_trap;
            ret_reg   <= take_ret;
          end
          if (take_trap) begin
            cause_reg   <= cause_next;
            trap_pc_reg <= commit_pc;
          end
        end
        ST_ISSUE: begin
          state_reg     <= ST_DRAIN;
          drain_cnt_reg <= DRAIN_LAST;
          stall_reg     <= 1'b1;
          flush_reg     <= 1'b0;
          raise_reg     <= 1'b0;
          ret_reg       <= 1'b0;
        end
        ST_DRAIN: begin
          if (drain_cnt_reg == '0) begin
            state_reg <= ST_IDLE;
            stall_reg <= 1'b0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - CW'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          stall_reg <= 1'b0;
          flush_reg <= 1'b0;
          raise_reg <= 1'b0;
          ret_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign stall      = stall_reg;
  assign flush      = flush_reg;
  assign raise_intr = raise_reg;
  assign ret        = ret_reg;
  assign NO         = cause_reg;
  assign trap_pc    = trap_pc_reg;

endmodule

// File: tb/tb_ysyx_220066_trap_ctrl.sv
// Directed bench for the trap sequencer: decode priority, issue/drain timing,
// timer compare, mtime wrap and asynchronous abort.
module tb_ysyx_220066_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commit_valid = 1'b0;
  logic [63:0] commit_pc = 64'h0;
  logic        commit_ecall = 1'b0;
  logic        commit_ill = 1'b0;
  logic        commit_mret = 1'b0;
  logic        mstatus_mie = 1'b0;
  logic        mie_mtie = 1'b0;
  logic        tmr_wen = 1'b0;
  logic        tmr_sel = 1'b0;
  logic [63:0] tmr_wdata = 64'h0;
  logic [63:0] mtime;
  logic        mtip;
  logic        stall;
  logic        flush;
  logic        raise_intr;
  logic        ret;
  logic [63:0] NO;
  logic [63:0] trap_pc;

  int n_assert = 0;
  int n_fail   = 0;

  ysyx_220066_trap_ctrl #(
    .TICK_DIV  (10),
    .DRAIN_CYC (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_ecall (commit_ecall),
    .commit_ill   (commit_ill),
    .commit_mret  (commit_mret),
    .mstatus_mie  (mstatus_mie),
    .mie_mtie     (mie_mtie),
    .tmr_wen      (tmr_wen),
    .tmr_sel      (tmr_sel),
    .tmr_wdata    (tmr_wdata),
    .mtime        (mtime),
    .mtip         (mtip),
    .stall        (stall),
    .flush        (flush),
    .raise_intr   (raise_intr),
    .ret          (ret),
    .NO           (NO),
    .trap_pc      (trap_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic commit(input logic [63:0] pc, input logic ill, input logic ecall, input logic mret);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_ill   = ill;
    commit_ecall = ecall;
    commit_mret  = mret;
  endtask

  task automatic no_commit();
    commit_valid = 1'b0;
    commit_ill   = 1'b0;
    commit_ecall = 1'b0;
    commit_mret  = 1'b0;
  endtask

  // After the ISSUE cycle: two DRAIN cycles with stall high, then IDLE.
  task automatic drain(input string tag);
    tick();
    chk({tag, "_d1_stall"}, 64'(stall), 64'd1);
    chk({tag, "_d1_flush"}, 64'(flush), 64'd0);
    chk({tag, "_d1_raise"}, 64'(raise_intr), 64'd0);
    tick();
    chk({tag, "_d2_stall"}, 64'(stall), 64'd1);
    tick();
    chk({tag, "_idle_stall"}, 64'(stall), 64'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    tick();
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_raise", 64'(raise_intr), 64'd0);
    chk("rst_ret", 64'(ret), 64'd0);
    chk("rst_no", NO, 64'd0);
    chk("rst_trap_pc", trap_pc, 64'd0);
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_mtip", 64'(mtip), 64'd0);
    rst = 1'b0;
    $display("step reset: done");

    // ecall with interrupts disabled
    commit(64'h8000_0010, 1'b0, 1'b1, 1'b0);
    tick();
    no_commit();
    chk("ecall_raise", 64'(raise_intr), 64'd1);
    chk("ecall_ret", 64'(ret), 64'd0);
    chk("ecall_flush", 64'(flush), 64'd1);
    chk("ecall_stall", 64'(stall), 64'd1);
    chk("ecall_no", NO, 64'd11);
    chk("ecall_pc", trap_pc, 64'h8000_0010);
    drain("ecall");
    $display("step ecall: pc=%h NO=%0d", trap_pc, NO);

    // all three flags together: illegal wins
    commit(64'h8000_0020, 1'b1, 1'b1, 1'b1);
    tick();
    no_commit();
    chk("multi_raise", 64'(raise_intr), 64'd1);
    chk("multi_ret", 64'(ret), 64'd0);
    chk("multi_no", NO, 64'd2);
    chk("multi_pc", trap_pc, 64'h8000_0020);
    drain("multi");
    $display("step ill+ecall+mret: NO=%0d", NO);

    // mret alone: ret pulse, cause and pc held
    commit(64'h8000_0030, 1'b0, 1'b0, 1'b1);
    tick();
    no_commit();
    chk("mret_ret", 64'(ret), 64'd1);
    chk("mret_raise", 64'(raise_intr), 64'd0);
    chk("mret_flush", 64'(flush), 64'd1);
    chk("mret_no", NO, 64'd2);
    chk("mret_pc", trap_pc, 64'h8000_0020);
    drain("mret");
    $display("step mret: ret pulse seen");

    // commit_valid low: flags ignored
    commit_ecall = 1'b1;
    tick();
    commit_ecall = 1'b0;
    chk("novalid_raise", 64'(raise_intr), 64'd0);
    chk("novalid_stall", 64'(stall), 64'd0);
    $display("step invalid commit: ignored");

    // timer: mtimecmp=5, then restart mtime from 0
    tmr_wen = 1'b1; tmr_sel = 1'b1; tmr_wdata = 64'd5;
    tick();
    tmr_sel = 1'b0; tmr_wdata = 64'd0;
    tick();
    tmr_wen = 1'b0;
    chk("tmr_start_mtime", mtime, 64'd0);
    chk("tmr_start_mtip", 64'(mtip), 64'd0);
    mstatus_mie = 1'b1;
    mie_mtie    = 1'b1;
    for (int i = 0; i < 49; i++) tick();
    chk("tmr_49_mtime", mtime, 64'd4);
    chk("tmr_49_mtip", 64'(mtip), 64'd0);
    tick();
    chk("tmr_50_mtime", mtime, 64'd5);
    chk("tmr_50_mtip", 64'(mtip), 64'd1);
    commit(64'h8000_0100, 1'b0, 1'b1, 1'b0);
    tick();
    no_commit();
    chk("mti_raise", 64'(raise_intr), 64'd1);
    chk("mti_no", NO, 64'h8000_0000_0000_0007);
    chk("mti_pc", trap_pc, 64'h8000_0100);
    drain("mti");
    $display("step timer irq: NO=%h pc=%h", NO, trap_pc);

    // pending but MIE=0: ecall taken instead
    mstatus_mie = 1'b0;
    commit(64'h8000_0200, 1'b0, 1'b1, 1'b0);
    tick();
    no_commit();
    chk("mie0_mtip", 64'(mtip), 64'd1);
    chk("mie0_no", NO, 64'd11);
    chk("mie0_pc", trap_pc, 64'h8000_0200);
    drain("mie0");
    $display("step mie=0: NO=%0d", NO);

    // pending but MTIE=0: illegal taken instead
    mstatus_mie = 1'b1;
    mie_mtie    = 1'b0;
    commit(64'h8000_0300, 1'b1, 1'b0, 1'b0);
    tick();
    no_commit();
    chk("mtie0_no", NO, 64'd2);
    chk("mtie0_pc", trap_pc, 64'h8000_0300);
    drain("mtie0");
    mstatus_mie = 1'b0;
    $display("step mtie=0: NO=%0d", NO);

    // mtime wrap
    tmr_wen = 1'b1; tmr_sel = 1'b0; tmr_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tmr_wen = 1'b0;
    chk("wrap_set_mtime", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_set_mtip", 64'(mtip), 64'd1);
    for (int i = 0; i < 9; i++) tick();
    chk("wrap_9_mtime", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("wrap_10_mtime", mtime, 64'd0);
    chk("wrap_10_mtip", 64'(mtip), 64'd0);
    $display("step wrap: mtime=%h mtip=%0d", mtime, mtip);

    // reset in the middle of ISSUE
    commit(64'h8000_0400, 1'b0, 1'b1, 1'b0);
    tick();
    no_commit();
    chk("abort_pre_raise", 64'(raise_intr), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_raise", 64'(raise_intr), 64'd0);
    chk("abort_stall", 64'(stall), 64'd0);
    chk("abort_flush", 64'(flush), 64'd0);
    chk("abort_mtime", mtime, 64'd0);
    chk("abort_no", NO, 64'd0);
    $display("step abort: outputs cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
